// File: rtl/id_exe_pipe_reg_pkg.sv
// Shared widths and control-bundle bit positions for the ID/EX pipeline register.
package id_exe_pipe_reg_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 5;
  localparam int unsigned WB_W_DEF   = 2;
  localparam int unsigned MEM_W_DEF  = 3;
  localparam int unsigned EXE_W_DEF  = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  // WB bundle
  localparam int unsigned WB_MEM_TO_REG = 0;
  localparam int unsigned WB_REG_WRITE  = 1;

  // MEM bundle
  localparam int unsigned MEM_WRITE  = 0;
  localparam int unsigned MEM_READ   = 1;
  localparam int unsigned MEM_BRANCH = 2;

  // EXE bundle
  localparam int unsigned EXE_ALU_SRC   = 0;
  localparam int unsigned EXE_ALU_OP_LO = 1;
  localparam int unsigned EXE_ALU_OP_HI = 2;
  localparam int unsigned EXE_REG_DST   = 3;

  localparam int unsigned MEM_READ_BIT_DEF = MEM_READ;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is a source of the
// valid instruction in ID.
module load_use_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             exValid,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exRd,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idValid,
  output logic             hazard
);

  logic rd_match;

  assign rd_match = (exRd == idRs) || (exRd == idRt);
  // $0 is never really written, so a load to it cannot cause a dependency
  assign hazard = exValid && exMemRead && (exRd != '0) && rd_match && idValid;

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID/EX pipeline register with valid bit, hold, flush-to-bubble, load-use
// bubble injection and a saturating bubble counter.
module id_exe_pipe_reg
  import id_exe_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned REG_W        = REG_W_DEF,
  parameter int unsigned WB_W         = WB_W_DEF,
  parameter int unsigned MEM_W        = MEM_W_DEF,
  parameter int unsigned EXE_W        = EXE_W_DEF,
  parameter int unsigned MEM_READ_BIT = MEM_READ_BIT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [DATA_W-1:0] sign_extended,
  input  logic [REG_W-1:0]  instruction1,
  input  logic [REG_W-1:0]  instruction2,
  input  logic [REG_W-1:0]  idRs,
  input  logic [REG_W-1:0]  idRt,
  input  logic              validIn,
  input  logic [WB_W-1:0]   WB,
  input  logic [MEM_W-1:0]  MEM,
  input  logic [EXE_W-1:0]  EXE,
  input  logic              hold,
  input  logic              flush,
  output logic [DATA_W-1:0] pcOut,
  output logic [DATA_W-1:0] readData1Out,
  output logic [DATA_W-1:0] readData2Out,
  output logic [DATA_W-1:0] sign_extendedOut,
  output logic [REG_W-1:0]  instruction1Out,
  output logic [REG_W-1:0]  instruction2Out,
  output logic [WB_W-1:0]   WBOut,
  output logic [MEM_W-1:0]  MEMOut,
  output logic [EXE_W-1:0]  EXEOut,
  output logic              validOut,
  output logic              stallOut,
  output logic [CNT_W-1:0]  bubbleCount
);

  logic hazard;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .exValid   (validOut),
    .exMemRead (MEMOut[MEM_READ_BIT]),
    .exRd      (instruction1Out),
    .idRs      (idRs),
    .idRt      (idRt),
    .idValid   (validIn),
    .hazard    (hazard)
  );

  // A taken branch squashes the dependent instruction, so no stall is needed
  assign stallOut = hazard & ~flush & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcOut            <= '0;
      readData1Out     <= '0;
      readData2Out     <= '0;
      sign_extendedOut <= '0;
      instruction1Out  <= '0;
      instruction2Out  <= '0;
      WBOut            <= '0;
      MEMOut           <= '0;
      EXEOut           <= '0;
      validOut         <= 1'b0;
      bubbleCount      <= '0;
    end else if (flush || (!hold && hazard)) begin
      // Bubble: data fields are don't-care, control and valid are cleared
      pcOut            <= pc;
      readData1Out     <= readData1;
      readData2Out     <= readData2;
      sign_extendedOut <= sign_extended;
      instruction1Out  <= instruction1;
      instruction2Out  <= instruction2;
      WBOut            <= '0;
      MEMOut           <= '0;
      EXEOut           <= '0;
      validOut         <= 1'b0;
      if (!flush && (bubbleCount != '1)) begin
        bubbleCount <= bubbleCount + CNT_W'(1);
      end
    end else if (!hold) begin
      pcOut            <= pc;
      readData1Out     <= readData1;
      readData2Out     <= readData2;
      sign_extendedOut <= sign_extended;
      instruction1Out  <= instruction1;
      instruction2Out  <= instruction2;
      WBOut            <= validIn ? WB  : '0;
      MEMOut           <= validIn ? MEM : '0;
      EXEOut           <= validIn ? EXE : '0;
      validOut         <= validIn;
    end
  end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Directed bench for id_exe_pipe_reg; a second instance with a 2-bit counter
// covers saturation.
module tb_id_exe_pipe_reg;

  logic        clock;
  logic        reset;
  logic [31:0] pc, readData1, readData2, sign_extended;
  logic [4:0]  instruction1, instruction2, idRs, idRt;
  logic        validIn, hold, flush;
  logic [1:0]  WB;
  logic [2:0]  MEM;
  logic [3:0]  EXE;

  logic [31:0] pcOut, readData1Out, readData2Out, sign_extendedOut;
  logic [4:0]  instruction1Out, instruction2Out;
  logic [1:0]  WBOut;
  logic [2:0]  MEMOut;
  logic [3:0]  EXEOut;
  logic        validOut, stallOut;
  logic [15:0] bubbleCount;

  logic [31:0] s_pcOut, s_readData1Out, s_readData2Out, s_sign_extendedOut;
  logic [4:0]  s_instruction1Out, s_instruction2Out;
  logic [1:0]  s_WBOut;
  logic [2:0]  s_MEMOut;
  logic [3:0]  s_EXEOut;
  logic        s_validOut, s_stallOut;
  logic [1:0]  s_bubbleCount;

  int vectors = 0;
  int errors  = 0;

  id_exe_pipe_reg dut (
    .clock(clock), .reset(reset), .pc(pc), .readData1(readData1),
    .readData2(readData2), .sign_extended(sign_extended),
    .instruction1(instruction1), .instruction2(instruction2),
    .idRs(idRs), .idRt(idRt), .validIn(validIn), .WB(WB), .MEM(MEM),
    .EXE(EXE), .hold(hold), .flush(flush), .pcOut(pcOut),
    .readData1Out(readData1Out), .readData2Out(readData2Out),
    .sign_extendedOut(sign_extendedOut), .instruction1Out(instruction1Out),
    .instruction2Out(instruction2Out), .WBOut(WBOut), .MEMOut(MEMOut),
    .EXEOut(EXEOut), .validOut(validOut), .stallOut(stallOut),
    .bubbleCount(bubbleCount)
  );

  id_exe_pipe_reg #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .pc(pc), .readData1(readData1),
    .readData2(readData2), .sign_extended(sign_extended),
    .instruction1(instruction1), .instruction2(instruction2),
    .idRs(idRs), .idRt(idRt), .validIn(validIn), .WB(WB), .MEM(MEM),
    .EXE(EXE), .hold(hold), .flush(flush), .pcOut(s_pcOut),
    .readData1Out(s_readData1Out), .readData2Out(s_readData2Out),
    .sign_extendedOut(s_sign_extendedOut), .instruction1Out(s_instruction1Out),
    .instruction2Out(s_instruction2Out), .WBOut(s_WBOut), .MEMOut(s_MEMOut),
    .EXEOut(s_EXEOut), .validOut(s_validOut), .stallOut(s_stallOut),
    .bubbleCount(s_bubbleCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    pc = '0; readData1 = '0; readData2 = '0; sign_extended = '0;
    instruction1 = '0; instruction2 = '0; idRs = '0; idRt = '0;
    validIn = 1'b0; WB = '0; MEM = '0; EXE = '0; hold = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    pc = 32'hA5A5A5A5; readData1 = 32'hA5A5A5A5; readData2 = 32'hA5A5A5A5;
    sign_extended = 32'hA5A5A5A5; instruction1 = 5'h1F; instruction2 = 5'h1F;
    idRs = 5'h1F; idRt = 5'h1F; validIn = 1'b1;
    WB = 2'b01; MEM = 3'b101; EXE = 4'b0101;
    tick();
    vectors++;
    if (pcOut !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL reset_preload_pc: got %h expected a5a5a5a5", pcOut);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (pcOut !== 32'h0 || readData2Out !== 32'h0 || instruction2Out !== 5'h0 ||
        WBOut !== 2'b0 || MEMOut !== 3'b0 || EXEOut !== 4'b0 || validOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: pc=%h rd2=%h i2=%h wb=%b mem=%b exe=%b v=%b expected all 0",
               pcOut, readData2Out, instruction2Out, WBOut, MEMOut, EXEOut, validOut);
    end
    vectors++;
    if (stallOut !== 1'b0 || bubbleCount !== 16'd0) begin
      errors++; $display("FAIL reset_stall_count: stall=%b count=%0d expected 0 0", stallOut, bubbleCount);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_normal();
    clear_inputs();
    pc = 32'h40; readData1 = 32'd7; WB = 2'b11; validIn = 1'b1;
    tick();
    vectors++;
    if (pcOut !== 32'h40 || readData1Out !== 32'd7) begin
      errors++; $display("FAIL normal_data: pc=%h rd1=%0d expected 40 7", pcOut, readData1Out);
    end
    vectors++;
    if (WBOut !== 2'b11 || validOut !== 1'b1 || stallOut !== 1'b0) begin
      errors++; $display("FAIL normal_ctrl: wb=%b v=%b stall=%b expected 11 1 0", WBOut, validOut, stallOut);
    end
  endtask

  task automatic test_invalid();
    clear_inputs();
    pc = 32'h44; WB = 2'b11; MEM = 3'b111; EXE = 4'hF; validIn = 1'b0;
    tick();
    vectors++;
    if (pcOut !== 32'h44 || validOut !== 1'b0 || WBOut !== 2'b0 || MEMOut !== 3'b0 || EXEOut !== 4'h0) begin
      errors++;
      $display("FAIL invalid_entry: pc=%h v=%b wb=%b mem=%b exe=%h expected 44 0 0 0 0",
               pcOut, validOut, WBOut, MEMOut, EXEOut);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    MEM = 3'b010; instruction1 = 5'd8; validIn = 1'b1; pc = 32'h50;
    tick();
    MEM = 3'b000; instruction1 = 5'd9; idRs = 5'd8; pc = 32'h100; WB = 2'b10;
    #1;
    vectors++;
    if (stallOut !== 1'b1) begin
      errors++; $display("FAIL loaduse_stall: got %b expected 1", stallOut);
    end
    tick();
    vectors++;
    if (validOut !== 1'b0 || MEMOut !== 3'b0 || WBOut !== 2'b0 || bubbleCount !== 16'd1) begin
      errors++;
      $display("FAIL loaduse_bubble: v=%b mem=%b wb=%b count=%0d expected 0 0 0 1",
               validOut, MEMOut, WBOut, bubbleCount);
    end
    vectors++;
    if (stallOut !== 1'b0) begin
      errors++; $display("FAIL loaduse_clear: stall=%b expected 0", stallOut);
    end
    tick();
    vectors++;
    if (validOut !== 1'b1 || pcOut !== 32'h100 || WBOut !== 2'b10 || bubbleCount !== 16'd1) begin
      errors++;
      $display("FAIL loaduse_resume: v=%b pc=%h wb=%b count=%0d expected 1 100 10 1",
               validOut, pcOut, WBOut, bubbleCount);
    end
  endtask

  task automatic test_load_r0();
    clear_inputs();
    MEM = 3'b010; instruction1 = 5'd0; validIn = 1'b1; pc = 32'h60;
    tick();
    vectors++;
    if (MEMOut !== 3'b010 || stallOut !== 1'b0) begin
      errors++; $display("FAIL r0_load: mem=%b stall=%b expected 010 0", MEMOut, stallOut);
    end
    MEM = 3'b000; pc = 32'h64;
    tick();
    vectors++;
    if (validOut !== 1'b1 || pcOut !== 32'h64 || bubbleCount !== 16'd1) begin
      errors++;
      $display("FAIL r0_no_bubble: v=%b pc=%h count=%0d expected 1 64 1", validOut, pcOut, bubbleCount);
    end
  endtask

  task automatic test_hold_flush();
    clear_inputs();
    pc = 32'h200; WB = 2'b01; EXE = 4'h9; validIn = 1'b1;
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h300 + 32'(i); WB = 2'(i + 2); EXE = 4'(i);
      tick();
      vectors++;
      if (pcOut !== 32'h200 || WBOut !== 2'b01 || EXEOut !== 4'h9 || validOut !== 1'b1) begin
        errors++;
        $display("FAIL hold_frozen[%0d]: pc=%h wb=%b exe=%h v=%b expected 200 01 9 1",
                 i, pcOut, WBOut, EXEOut, validOut);
      end
    end
    flush = 1'b1;
    tick();
    vectors++;
    if (validOut !== 1'b0 || WBOut !== 2'b0 || MEMOut !== 3'b0 || EXEOut !== 4'h0) begin
      errors++;
      $display("FAIL hold_flush: v=%b wb=%b mem=%b exe=%h expected 0 0 0 0", validOut, WBOut, MEMOut, EXEOut);
    end
  endtask

  task automatic test_flush_hazard();
    clear_inputs();
    MEM = 3'b010; instruction1 = 5'd4; validIn = 1'b1;
    tick();
    MEM = 3'b000; idRt = 5'd4; flush = 1'b1;
    #1;
    vectors++;
    if (stallOut !== 1'b0) begin
      errors++; $display("FAIL flush_masks_stall: stall=%b expected 0", stallOut);
    end
    tick();
    vectors++;
    if (validOut !== 1'b0 || bubbleCount !== 16'd1) begin
      errors++; $display("FAIL flush_count: v=%b count=%0d expected 0 1", validOut, bubbleCount);
    end
  endtask

  task automatic test_saturation();
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    clear_inputs();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    MEM = 3'b010; instruction1 = 5'd6; idRs = 5'd6; validIn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (s_stallOut !== 1'b1 || stallOut !== 1'b1) begin
        errors++; $display("FAIL sat_stall[%0d]: sat=%b wide=%b expected 1 1", i, s_stallOut, stallOut);
      end
      tick();
      vectors++;
      if (s_bubbleCount !== 2'(sat_exp[i]) || bubbleCount !== 16'(i + 1)) begin
        errors++;
        $display("FAIL sat_count[%0d]: sat=%0d wide=%0d expected %0d %0d",
                 i, s_bubbleCount, bubbleCount, sat_exp[i], i + 1);
      end
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #12 reset = 1'b0;
    test_reset();
    test_normal();
    test_invalid();
    test_load_use();
    test_load_r0();
    test_hold_flush();
    test_flush_hazard();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
